// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory arbiter: FSM state encoding and requester identity,
// plus the round-robin owner selection used when both ports ask at once.
package lc3_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } requester_t;

  // On a tie the requester that was not served last wins.
  function automatic requester_t pick_owner(input logic cpu_req, input logic dbg_req,
                                            input requester_t last_served);
    requester_t winner;
    if (cpu_req && dbg_req) begin
      winner = (last_served == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (dbg_req) begin
      winner = REQ_DBG;
    end else begin
      winner = REQ_CPU;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single fixed-latency memory.
// One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LATENCY -> DONE.
module mem_arbiter
  import lc3_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuReq,
  input  logic        cpuWE,
  input  logic [15:0] cpuAddr,
  input  logic [15:0] cpuWData,
  output logic [15:0] cpuRData,
  output logic        cpuAck,
  input  logic        dbgReq,
  input  logic        dbgWE,
  input  logic [15:0] dbgAddr,
  input  logic [15:0] dbgWData,
  output logic [15:0] dbgRData,
  output logic        dbgAck,
  output logic        memEn,
  output logic        memWE,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  input  logic [15:0] memRData,
  output logic        grantDbg
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LATENCY - 1);

  arbState_t   state_r;
  requester_t  owner_r;
  requester_t  last_served_r;
  requester_t  next_owner_s;
  logic        cmd_we_r;
  logic [1:0]  count_r;
  logic        sel_we_s;
  logic [15:0] sel_addr_s;
  logic [15:0] sel_wdata_s;

  // Pick the would-be owner and mux its command for latching in IDLE.
  always_comb begin
    next_owner_s = pick_owner(cpuReq, dbgReq, last_served_r);
    if (next_owner_s == REQ_DBG) begin
      sel_we_s    = dbgWE;
      sel_addr_s  = dbgAddr;
      sel_wdata_s = dbgWData;
    end else begin
      sel_we_s    = cpuWE;
      sel_addr_s  = cpuAddr;
      sel_wdata_s = cpuWData;
    end
  end

  // Arbiter FSM; every output is a register so memEn and the acks are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ARB_IDLE;
      owner_r       <= REQ_CPU;
      last_served_r <= REQ_DBG;
      cmd_we_r      <= 1'b0;
      count_r       <= 2'd0;
      memEn         <= 1'b0;
      memWE         <= 1'b0;
      memAddr       <= 16'h0000;
      memWData      <= 16'h0000;
      cpuAck        <= 1'b0;
      dbgAck        <= 1'b0;
      cpuRData      <= 16'h0000;
      dbgRData      <= 16'h0000;
      grantDbg      <= 1'b0;
    end else begin
      // Strobes default low; the command bus is zero whenever memEn is low.
      memEn    <= 1'b0;
      memWE    <= 1'b0;
      memAddr  <= 16'h0000;
      memWData <= 16'h0000;
      cpuAck   <= 1'b0;
      dbgAck   <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (cpuReq || dbgReq) begin
            owner_r  <= next_owner_s;
            cmd_we_r <= sel_we_s;
            grantDbg <= (next_owner_s == REQ_DBG);
            memEn    <= 1'b1;
            memWE    <= sel_we_s;
            memAddr  <= sel_addr_s;
            memWData <= sel_wdata_s;
            state_r  <= ARB_ISSUE;
          end else begin
            state_r  <= ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          count_r <= LAT_LOAD;
          state_r <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (count_r == 2'd0) begin
            // memRData is valid in this cycle; capture it for reads only.
            if (!cmd_we_r && owner_r == REQ_DBG) begin
              dbgRData <= memRData;
            end else if (!cmd_we_r) begin
              cpuRData <= memRData;
            end else begin
              cpuRData <= cpuRData;
            end
            cpuAck  <= (owner_r == REQ_CPU);
            dbgAck  <= (owner_r == REQ_DBG);
            state_r <= ARB_DONE;
          end else begin
            count_r <= count_r - 2'd1;
          end
        end
        ARB_DONE: begin
          last_served_r <= owner_r;
          grantDbg      <= 1'b0;
          state_r       <= ARB_IDLE;
        end
        default: begin
          grantDbg <= 1'b0;
          state_r  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=4, each with a
// latency-accurate memory responder; a transaction-level model predicts every output per cycle.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [1:0]       cpu_ack, dbg_ack, mem_en, mem_we, grant_dbg;
  logic [1:0][15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [1:0][15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset[0]),
    .cpuReq(cpu_req[0]), .cpuWE(cpu_we[0]), .cpuAddr(cpu_addr[0]), .cpuWData(cpu_wdata[0]),
    .cpuRData(cpu_rdata[0]), .cpuAck(cpu_ack[0]),
    .dbgReq(dbg_req[0]), .dbgWE(dbg_we[0]), .dbgAddr(dbg_addr[0]), .dbgWData(dbg_wdata[0]),
    .dbgRData(dbg_rdata[0]), .dbgAck(dbg_ack[0]),
    .memEn(mem_en[0]), .memWE(mem_we[0]), .memAddr(mem_addr[0]), .memWData(mem_wdata[0]),
    .memRData(mem_rdata[0]), .grantDbg(grant_dbg[0])
  );

  mem_arbiter #(.MEM_LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset[1]),
    .cpuReq(cpu_req[1]), .cpuWE(cpu_we[1]), .cpuAddr(cpu_addr[1]), .cpuWData(cpu_wdata[1]),
    .cpuRData(cpu_rdata[1]), .cpuAck(cpu_ack[1]),
    .dbgReq(dbg_req[1]), .dbgWE(dbg_we[1]), .dbgAddr(dbg_addr[1]), .dbgWData(dbg_wdata[1]),
    .dbgRData(dbg_rdata[1]), .dbgAck(dbg_ack[1]),
    .memEn(mem_en[1]), .memWE(mem_we[1]), .memAddr(mem_addr[1]), .memWData(mem_wdata[1]),
    .memRData(mem_rdata[1]), .grantDbg(grant_dbg[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rsp_mem [2][65536];
  bit          rsp_wr  [2][65536];
  logic [15:0] ref_mem [2][65536];
  bit          ref_wr  [2][65536];
  int          rd_cnt  [2];
  logic [15:0] rd_addr [2];
  logic [15:0] rexp    [2][2];
  int          last_srv[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h2234;
  endfunction

  function automatic logic [15:0] mem_word(input int g, input logic [15:0] a);
    return rsp_wr[g][a] ? rsp_mem[g][a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_word(input int g, input logic [15:0] a);
    return ref_wr[g][a] ? ref_mem[g][a] : init_word(a);
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = {12'h300, 4'($urandom_range(0, 15))};
    t.wd   = 16'($urandom);
    return t;
  endfunction

  // Memory: data valid exactly MEM_LATENCY cycles after memEn, random junk at all other times.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_en[g] && mem_we[g]) begin
        rsp_mem[g][mem_addr[g]] <= mem_wdata[g];
        rsp_wr[g][mem_addr[g]]  <= 1'b1;
      end
      if (mem_en[g] && !mem_we[g]) begin
        rd_addr[g]   <= mem_addr[g];
        rd_cnt[g]    <= lat_of(g) - 1;
        mem_rdata[g] <= (lat_of(g) == 1) ? mem_word(g, mem_addr[g]) : 16'($urandom);
      end else if (rd_cnt[g] > 0) begin
        rd_cnt[g]    <= rd_cnt[g] - 1;
        mem_rdata[g] <= (rd_cnt[g] == 1) ? mem_word(g, rd_addr[g]) : 16'($urandom);
      end else begin
        mem_rdata[g] <= 16'($urandom);
      end
    end
  end

  task automatic check(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut%0d): observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  task automatic check_cycle(input int i, input bit e_cack, input bit e_dack, input bit e_en,
                             input txn_t c, input bit e_gnt);
    check("cpuAck",   i, 16'(cpu_ack[i]),   16'(e_cack));
    check("dbgAck",   i, 16'(dbg_ack[i]),   16'(e_dack));
    check("memEn",    i, 16'(mem_en[i]),    16'(e_en));
    check("memWE",    i, 16'(mem_we[i]),    e_en ? 16'(c.we) : 16'h0000);
    check("memAddr",  i, mem_addr[i],       e_en ? c.addr : 16'h0000);
    check("memWData", i, mem_wdata[i],      e_en ? c.wd : 16'h0000);
    check("grantDbg", i, 16'(grant_dbg[i]), 16'(e_gnt));
    check("cpuRData", i, cpu_rdata[i],      rexp[i][0]);
    check("dbgRData", i, dbg_rdata[i],      rexp[i][1]);
  endtask

  task automatic check_quiet(input int i);
    txn_t z;
    z = '0;
    rexp[i][0] = 16'h0000;
    rexp[i][1] = 16'h0000;
    check_cycle(i, 1'b0, 1'b0, 1'b0, z, 1'b0);
  endtask

  // Runs ncpu CPU and ndbg debug transactions on instance i from an idle arbiter, checking each cycle.
  task automatic run(input int i, input int ncpu, input int ndbg, input bit drop_cpu,
                     input txn_t c0, input txn_t d0);
    int   n[2], issued[2];
    bit   have[2], dropped[2], p[2];
    txn_t cur[2];
    txn_t cmd;
    int   owner, en_k, ack_k, idle_k, quiet, lat;
    lat = lat_of(i);
    n[0] = ncpu; n[1] = ndbg;
    issued = '{0, 0}; have = '{1'b0, 1'b0}; dropped = '{1'b0, 1'b0};
    cur[0] = '0; cur[1] = '0; cmd = '0;
    owner = -1; en_k = -1; ack_k = -1; idle_k = 0; quiet = 0;
    for (int k = 0; k < 400; k++) begin
      if (owner >= 0 && k == ack_k) begin
        if (cmd.we) begin
          ref_mem[i][cmd.addr] = cmd.wd;
          ref_wr[i][cmd.addr]  = 1'b1;
        end else begin
          rexp[i][owner] = ref_word(i, cmd.addr);
        end
      end
      check_cycle(i, owner == 0 && k == ack_k, owner == 1 && k == ack_k,
                  owner >= 0 && k == en_k, cmd, owner == 1);
      if (owner >= 0 && k == ack_k) begin
        n[owner]--; have[owner] = 1'b0; dropped[owner] = 1'b0;
        last_srv[i] = owner;
        owner = -1;
      end
      if (drop_cpu && owner == 0 && k == en_k) dropped[0] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        if (!have[r] && n[r] > 0) begin
          cur[r] = (issued[r] == 0) ? ((r == 0) ? c0 : d0) : rand_txn();
          issued[r]++;
          have[r] = 1'b1;
        end
        p[r] = have[r] && !dropped[r];
      end
      cpu_req[i] = p[0]; cpu_we[i] = cur[0].we; cpu_addr[i] = cur[0].addr; cpu_wdata[i] = cur[0].wd;
      dbg_req[i] = p[1]; dbg_we[i] = cur[1].we; dbg_addr[i] = cur[1].addr; dbg_wdata[i] = cur[1].wd;
      if (owner < 0 && k >= idle_k) begin
        if (p[0] || p[1]) begin
          owner  = (p[0] && p[1]) ? ((last_srv[i] == 0) ? 1 : 0) : (p[1] ? 1 : 0);
          cmd    = cur[owner];
          en_k   = k + 1;
          ack_k  = k + lat + 2;
          idle_k = k + lat + 3;
        end else begin
          idle_k = k + 1;
        end
      end
      if (owner < 0 && n[0] == 0 && n[1] == 0) quiet++;
      @(negedge clk);
      if (quiet >= 4) break;
    end
  endtask

  initial begin
    txn_t c, d, none;
    none = '0;
    reset = 2'b11;
    cpu_req = 2'b00; cpu_we = 2'b00; dbg_req = 2'b00; dbg_we = 2'b00;
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    last_srv = '{1, 1};
    repeat (3) @(negedge clk);
    reset = 2'b00;
    check_quiet(0);
    check_quiet(1);

    // Single CPU read of 0x3000; memory content there is 0x1234.
    c = '{we: 1'b0, addr: 16'h3000, wd: 16'h0000};
    run(0, 1, 0, 1'b0, c, none);
    check("cpu_read_0x3000", 0, cpu_rdata[0], 16'h1234);

    // Debug write 0xBEEF to 0x0010; dbgRData stays at its reset value.
    d = '{we: 1'b1, addr: 16'h0010, wd: 16'hBEEF};
    run(0, 0, 1, 1'b0, none, d);
    check("dbg_write_rdata", 0, dbg_rdata[0], 16'h0000);

    // Both request together, CPU held for a second access: CPU, DBG, CPU; then read back 0x0010.
    c = '{we: 1'b0, addr: 16'h0010, wd: 16'h0000};
    d = '{we: 1'b0, addr: 16'h3001, wd: 16'h0000};
    run(0, 2, 1, 1'b0, c, d);
    check("readback_0x0010", 0, ref_word(0, 16'h0010), 16'hBEEF);

    // CPU drops its request during ISSUE; the transaction still completes exactly once.
    c = '{we: 1'b1, addr: 16'h3002, wd: 16'h5A5A};
    run(0, 1, 0, 1'b1, c, none);
    run(0, 2, 2, 1'b1, rand_txn(), rand_txn());

    for (int t = 0; t < 20; t++) begin
      run(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rand_txn(), rand_txn());
    end

    // Latency 4: CPU read acked 6 cycles after sampling, data from the valid cycle only.
    c = '{we: 1'b0, addr: 16'h3000, wd: 16'h0000};
    run(1, 1, 0, 1'b0, c, none);
    check("lat4_read_0x3000", 1, cpu_rdata[1], 16'h1234);

    // Reset pulsed while in WAIT discards the transaction.
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 16'h3007;
    @(negedge clk);
    check("abort_issue_memEn", 1, 16'(mem_en[1]), 16'h0001);
    @(negedge clk);
    reset[1] = 1'b1; cpu_req[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b0;
    last_srv[1] = 1;
    for (int q = 0; q < 7; q++) begin
      check_quiet(1);
      @(negedge clk);
    end
    c = '{we: 1'b0, addr: 16'h3005, wd: 16'h0000};
    d = '{we: 1'b1, addr: 16'h3005, wd: 16'hC0DE};
    run(1, 1, 1, 1'b0, c, d);
    check("post_reset_cpu_read", 1, cpu_rdata[1], 16'h3005 ^ 16'h2234);

    for (int t = 0; t < 10; t++) begin
      run(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rand_txn(), rand_txn());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
